tc_operand_loader: RTL and testbench
====================================

// Module: tc_operand_loader
// PURPOSE
//  Upstream feeder for tc_core. Takes operand rows as a valid/ready stream and assembles them into the
//  flat in_a (M x K) and in_b (N x K) buses. It then sequences tc_core: load_en for LOAD_CYCLES, then
//  compute_en for COMPUTE_CYCLES, then a done pulse. Replaces hand-driven load/compute timing in system use.
// PARAMETERS
//  M              16  rows of A
//  N              16  rows of B (B stored N x K, row n = column n of the math operand)
//  K              16  elements per row
//  DW_DATA        8   element width
//  LOAD_CYCLES    2   cycles load_en is held high (>=1)
//  COMPUTE_CYCLES 32  cycles compute_en is held high (>=1); = iterN*iterK of tc_core
// PORTS
//  clk         in   1              clock, all logic rising-edge
//  reset       in   1              synchronous, active-high
//  s_valid     in   1              row beat valid
//  s_ready     out  1              row beat accept
//  s_data      in   K*DW_DATA      one row; element j at [j*DW_DATA +: DW_DATA]
//  s_last      in   1              marks final row (row M+N-1) of a batch; checked only
//  in_a        out  M*K*DW_DATA    to tc_core.in_a; A[i][j] at [(i*K+j)*DW_DATA +: DW_DATA]
//  in_b        out  N*K*DW_DATA    to tc_core.in_b; B[n][j] at [(n*K+j)*DW_DATA +: DW_DATA]
//  load_en     out  1              to tc_core.load_en
//  compute_en  out  1              to tc_core.compute_en
//  busy        out  1              high in LOAD, COMPUTE, DONE
//  done        out  1              one-cycle pulse at end of compute
//  err         out  1              sticky s_last position mismatch
// BEHAVIOUR
//  - Reset (any state, mid-batch included): state=FILL, row_cnt=0, phase_cnt=0, in_a/in_b all 0,
//    load_en=compute_en=done=err=busy=0; s_ready=1 the first cycle after reset is sampled low.
//  - Beat transfer = s_valid & s_ready at rising edge. s_ready=1 only in FILL; all outputs registered.
//  - FILL: beat r (0..M-1) writes A row r; beat r (M..M+N-1) writes B row r-M. row_cnt++ per beat.
//    Gaps in s_valid are allowed; no beat is dropped or duplicated. No write outside FILL.
//  - s_last check per beat: (s_last != (row_cnt==M+N-1)) -> err<=1, sticky until reset.
//    Placement is positional; a bad s_last does not alter fill order or counts.
//  - Beat M+N-1 accepted at edge E: next state LOAD, row_cnt<=0. load_en=1 for exactly LOAD_CYCLES cycles
//    starting the cycle after E.
//  - LOAD -> COMPUTE with no gap/overlap: compute_en rises the cycle load_en falls.
//    compute_en=1 for exactly COMPUTE_CYCLES cycles.
//  - COMPUTE -> DONE: done=1 for 1 cycle, compute_en=0, s_ready=0. DONE -> FILL next cycle.
//  - in_a/in_b are stable from E+1 through DONE. A new batch overwrites row by row; old rows persist
//    until rewritten.
//  - FSM: FILL -(last beat)-> LOAD -(phase_cnt==LOAD_CYCLES-1)-> COMPUTE
//    -(phase_cnt==COMPUTE_CYCLES-1)-> DONE -> FILL.
//    phase_cnt clears on each state change.
//  - Counter widths: row_cnt $clog2(M+N+1); phase_cnt $clog2(max(LOAD_CYCLES,COMPUTE_CYCLES)+1).
//    No wrap is reachable.
//  - Batch latency, last beat to done: LOAD_CYCLES+COMPUTE_CYCLES+1 cycles.
// STRUCTURE
//  - Shared package tc_pkg: state encoding (FILL, LOAD, COMPUTE, DONE); default M/N/K/DW_DATA;
//    row-slice index helper.
//  - Sub-module tc_row_buffer #(ROWS,K,DW_DATA): sync-reset register array with row write-enable and
//    row index. Flat read bus. Instantiated twice (A with ROWS=M, B with ROWS=N).
//  - Top holds FSM, counters, s_last check.
// TESTING
//  1 Reset held 3 cycles, then released -> all outputs 0, s_ready=1 next cycle, state FILL.
//  2 32 back-to-back beats, every byte of row r = r, s_last on beat 31 only ->
//    in_a byte(i*K+j)=i, in_b byte(n*K+j)=16+n. load_en high 2 cycles after last beat,
//    then compute_en 32 cycles, done once, err=0.
//  3 Same data, s_valid high every other cycle -> identical in_a/in_b, s_ready=0 from last beat
//    through done, 35 cycles total.
//  4 s_last on beat 5 and not on beat 31 -> err=1 from beat 5 onward; batch still completes, done pulses once.
//  5 Reset asserted on the 10th compute_en cycle -> next cycle compute_en=0, busy=0, buffers 0,
//    err=0, s_ready=1.
//  6 Two batches back-to-back, batch 2 bytes = 0xA0+r -> second load_en starts only after first done.
//    Buffers fully replaced; done pulses twice.

Source files
------------

// File: rtl/tc_pkg.sv
// rtl/tc_pkg.sv - shared types, defaults and helpers for the tensor-core operand loader
// Purpose : FSM state encoding, default operand geometry, row-slice index helper.
// Contents: tc_state_e, TC_M/TC_N/TC_K/TC_DW_DATA, tc_row_lsb().
package tc_pkg;

  localparam int TC_M       = 16;
  localparam int TC_N       = 16;
  localparam int TC_K       = 16;
  localparam int TC_DW_DATA = 8;

  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DONE    = 2'd3
  } tc_state_e;

  // LSB position of row 'row' inside a flat bus of k elements of dw bits per row.
  function automatic int unsigned tc_row_lsb(input int unsigned row,
                                             input int unsigned k,
                                             input int unsigned dw);
    return row * k * dw;
  endfunction

endpackage

// File: rtl/tc_row_buffer.sv
// rtl/tc_row_buffer.sv - row-addressed operand register array with flat read bus
// Purpose : holds ROWS rows of K elements; one row written per enabled cycle.
// Ports   : clk, reset (sync, active-high), i_we (row write enable),
//           i_row (row index), i_data (one row), o_flat (all rows, row r at r*K*DW_DATA).
module tc_row_buffer
  import tc_pkg::*;
#(
  parameter int ROWS    = TC_M,
  parameter int K       = TC_K,
  parameter int DW_DATA = TC_DW_DATA,
  parameter int IDX_W   = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_we,
  input  logic [IDX_W-1:0]           i_row,
  input  logic [K*DW_DATA-1:0]       i_data,
  output logic [ROWS*K*DW_DATA-1:0]  o_flat
);

  localparam int ROW_W = K * DW_DATA;

  logic [ROWS*ROW_W-1:0] r_mem;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem <= '0;
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        if (i_we && (i_row == IDX_W'(r))) begin
          r_mem[tc_row_lsb(r, K, DW_DATA) +: ROW_W] <= i_data;
        end
      end
    end
  end

  assign o_flat = r_mem;

endmodule

// File: rtl/tc_operand_loader.sv
// rtl/tc_operand_loader.sv - stream-to-operand assembler and load/compute sequencer for tc_core
// Purpose : accepts M+N operand rows on a valid/ready stream, fills A then B buffers,
//           then drives load_en for LOAD_CYCLES, compute_en for COMPUTE_CYCLES, and a done pulse.
// Ports   : clk, reset (sync, active-high);
//           s_valid/s_ready/s_data/s_last - row stream (s_last is checked, not obeyed);
//           in_a/in_b - flat operand buses to tc_core;
//           load_en/compute_en - tc_core sequencing; busy/done - status; err - sticky s_last mismatch.
module tc_operand_loader
  import tc_pkg::*;
#(
  parameter int M              = TC_M,
  parameter int N              = TC_N,
  parameter int K              = TC_K,
  parameter int DW_DATA        = TC_DW_DATA,
  parameter int LOAD_CYCLES    = 2,
  parameter int COMPUTE_CYCLES = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [K*DW_DATA-1:0]    s_data,
  input  logic                    s_last,
  output logic [M*K*DW_DATA-1:0]  in_a,
  output logic [N*K*DW_DATA-1:0]  in_b,
  output logic                    load_en,
  output logic                    compute_en,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int RCW  = $clog2(M + N + 1);
  localparam int PMAX = (LOAD_CYCLES > COMPUTE_CYCLES) ? LOAD_CYCLES : COMPUTE_CYCLES;
  localparam int PCW  = $clog2(PMAX + 1);

  localparam logic [RCW-1:0] LAST_ROW = RCW'(M + N - 1);
  localparam logic [RCW-1:0] FIRST_B  = RCW'(M);
  localparam logic [PCW-1:0] LOAD_END = PCW'(LOAD_CYCLES - 1);
  localparam logic [PCW-1:0] COMP_END = PCW'(COMPUTE_CYCLES - 1);

  tc_state_e        r_state;
  logic [RCW-1:0]   r_row_cnt;
  logic [PCW-1:0]   r_phase_cnt;
  logic             r_s_ready;
  logic             r_load_en;
  logic             r_compute_en;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic             w_beat;
  logic             w_is_last;
  logic             w_we_a;
  logic             w_we_b;
  logic [RCW-1:0]   w_row_b;

  // r_s_ready is only ever high in FILL, so a beat implies FILL.
  assign w_beat    = s_valid & r_s_ready;
  assign w_is_last = (r_row_cnt == LAST_ROW);
  assign w_we_a    = w_beat & (r_row_cnt < FIRST_B);
  assign w_we_b    = w_beat & (r_row_cnt >= FIRST_B);
  assign w_row_b   = r_row_cnt - FIRST_B;

  tc_row_buffer #(
    .ROWS(M), .K(K), .DW_DATA(DW_DATA), .IDX_W(RCW)
  ) u_buf_a (
    .clk(clk), .reset(reset), .i_we(w_we_a), .i_row(r_row_cnt),
    .i_data(s_data), .o_flat(in_a)
  );

  tc_row_buffer #(
    .ROWS(N), .K(K), .DW_DATA(DW_DATA), .IDX_W(RCW)
  ) u_buf_b (
    .clk(clk), .reset(reset), .i_we(w_we_b), .i_row(w_row_b),
    .i_data(s_data), .o_flat(in_b)
  );

  // Outputs are set on the transition into each state so they line up
  // exactly with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_FILL;
      r_row_cnt    <= '0;
      r_phase_cnt  <= '0;
      r_s_ready    <= 1'b0;
      r_load_en    <= 1'b0;
      r_compute_en <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        ST_FILL: begin
          r_s_ready <= 1'b1;
          if (w_beat) begin
            // Positional check only; fill order ignores s_last.
            if (s_last != w_is_last) r_err <= 1'b1;
            if (w_is_last) begin
              r_state     <= ST_LOAD;
              r_row_cnt   <= '0;
              r_phase_cnt <= '0;
              r_s_ready   <= 1'b0;
              r_load_en   <= 1'b1;
              r_busy      <= 1'b1;
            end else begin
              r_row_cnt <= r_row_cnt + 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (r_phase_cnt == LOAD_END) begin
            r_state      <= ST_COMPUTE;
            r_phase_cnt  <= '0;
            r_load_en    <= 1'b0;
            r_compute_en <= 1'b1;
          end else begin
            r_phase_cnt <= r_phase_cnt + 1'b1;
          end
        end
        ST_COMPUTE: begin
          if (r_phase_cnt == COMP_END) begin
            r_state      <= ST_DONE;
            r_phase_cnt  <= '0;
            r_compute_en <= 1'b0;
            r_done       <= 1'b1;
          end else begin
            r_phase_cnt <= r_phase_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          r_state   <= ST_FILL;
          r_done    <= 1'b0;
          r_busy    <= 1'b0;
          r_s_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_FILL;
        end
      endcase
    end
  end

  assign s_ready    = r_s_ready;
  assign load_en    = r_load_en;
  assign compute_en = r_compute_en;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_tc_operand_loader.sv
// tb/tb_tc_operand_loader.sv - directed self-checking bench for tc_operand_loader
module tb_tc_operand_loader;

  localparam int M  = 16;
  localparam int N  = 16;
  localparam int K  = 16;
  localparam int DW = 8;
  localparam int AW = M * K * DW;
  localparam int BW = N * K * DW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [K*DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic [AW-1:0] in_a;
  logic [BW-1:0] in_b;
  logic          load_en;
  logic          compute_en;
  logic          busy;
  logic          done;
  logic          err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [AW-1:0] exp_a;
  logic [BW-1:0] exp_b;
  logic [AW-1:0] snap_a;
  logic [BW-1:0] snap_b;

  tc_operand_loader #(
    .M(M), .N(N), .K(K), .DW_DATA(DW), .LOAD_CYCLES(2), .COMPUTE_CYCLES(32)
  ) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .in_a(in_a), .in_b(in_b),
    .load_en(load_en), .compute_en(compute_en),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s got=%0d want=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_bufs(input string tag, input logic [AW-1:0] oa, input logic [BW-1:0] ob);
    int idx;
    logic [7:0] gv;
    logic [7:0] wv;
    idx = -1;
    gv  = '0;
    wv  = '0;
    for (int b = M*K + N*K - 1; b >= 0; b--) begin
      if (b >= M*K) begin
        if (ob[(b-M*K)*8 +: 8] !== exp_b[(b-M*K)*8 +: 8]) begin
          idx = b; gv = ob[(b-M*K)*8 +: 8]; wv = exp_b[(b-M*K)*8 +: 8];
        end
      end else begin
        if (oa[b*8 +: 8] !== exp_a[b*8 +: 8]) begin
          idx = b; gv = oa[b*8 +: 8]; wv = exp_a[b*8 +: 8];
        end
      end
    end
    checks++;
    assert (oa === exp_a && ob === exp_b) else begin
      failures++;
      $error("FAIL %s first_bad_byte=%0d (A then B) got=%02h want=%02h", tag, idx, gv, wv);
    end
  endtask

  task automatic build_exp(input int base);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < K; j++)
        exp_a[(i*K+j)*8 +: 8] = 8'(base + i);
    for (int n = 0; n < N; n++)
      for (int j = 0; j < K; j++)
        exp_b[(n*K+j)*8 +: 8] = 8'(base + M + n);
  endtask

  task automatic set_row(input int v, input bit last);
    for (int j = 0; j < K; j++) s_data[j*8 +: 8] = 8'(v);
    s_last = last;
  endtask

  task automatic send_beat(input int v, input bit last, input int gap);
    int waited;
    set_row(v, last);
    s_valid = 1'b1;
    waited  = 0;
    while (s_ready !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    if (waited >= 50) begin
      checks++;
      failures++;
      $error("FAIL beat_wait got=timeout want=s_ready");
    end else begin
      tick();
    end
    if (gap > 0) begin
      s_valid = 1'b0;
      s_last  = 1'b0;
      repeat (gap) tick();
    end
  endtask

  // Called right after the edge that accepted the last beat.
  task automatic check_batch(input string tag, input int base);
    int n_load, n_comp, n_done, n_nready, n_busy, overlap;
    int first_load, first_comp, done_at;
    n_load = 0; n_comp = 0; n_done = 0; n_nready = 0; n_busy = 0; overlap = 0;
    first_load = 0; first_comp = 0; done_at = 0;
    build_exp(base);
    for (int c = 1; c <= 35; c++) begin
      if (load_en) begin n_load++; if (first_load == 0) first_load = c; end
      if (compute_en) begin n_comp++; if (first_comp == 0) first_comp = c; end
      if (done) begin n_done++; done_at = c; end
      if (!s_ready) n_nready++;
      if (busy) n_busy++;
      if (load_en && compute_en) overlap++;
      if (c == 35) begin snap_a = in_a; snap_b = in_b; end
      tick();
    end
    check({tag, "_load_cycles"}, n_load, 2);
    check({tag, "_load_start"}, first_load, 1);
    check({tag, "_comp_start"}, first_comp, 3);
    check({tag, "_comp_cycles"}, n_comp, 32);
    check({tag, "_overlap"}, overlap, 0);
    check({tag, "_done_count"}, n_done, 1);
    check({tag, "_done_at"}, done_at, 35);
    check({tag, "_nready_cycles"}, n_nready, 35);
    check({tag, "_busy_cycles"}, n_busy, 35);
    check_bufs({tag, "_bufs_at_done"}, snap_a, snap_b);
    check({tag, "_ready_after"}, s_ready, 1);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_done_after"}, done, 0);
  endtask

  initial begin
    int t0;
    int n;

    // 1: reset held 3 cycles
    reset = 1'b1;
    repeat (3) tick();
    exp_a = '0;
    exp_b = '0;
    check("rst_s_ready", s_ready, 0);
    check("rst_load_en", load_en, 0);
    check("rst_compute_en", compute_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check_bufs("rst_bufs", in_a, in_b);
    reset = 1'b0;
    tick();
    check("rel_s_ready", s_ready, 1);
    check("rel_busy", busy, 0);

    // 2: back-to-back batch
    t0 = cyc;
    for (int r = 0; r < 32; r++) send_beat(r, r == 31, 0);
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("b2b_fill_cycles", cyc - t0, 32);
    check_batch("b2b", 0);
    check("b2b_err", err, 0);

    // 3: s_valid every other cycle
    t0 = cyc;
    for (int r = 0; r < 32; r++) send_beat(r, r == 31, (r == 31) ? 0 : 1);
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("gap_fill_cycles", cyc - t0, 63);
    check_batch("gap", 0);
    check("gap_err", err, 0);

    // 4: misplaced s_last
    for (int r = 0; r < 32; r++) begin
      send_beat(r, r == 5, 0);
      if (r == 4) check("bad_last_err_before", err, 0);
      if (r == 5) check("bad_last_err_at5", err, 1);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    check_batch("bad_last", 0);
    check("bad_last_err_sticky", err, 1);

    // 5: reset on the 10th compute_en cycle
    for (int r = 0; r < 32; r++) send_beat(r, r == 31, 0);
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("midrst_err_still", err, 1);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (compute_en) n++;
      if (n == 10) break;
      tick();
    end
    check("midrst_reach_10", n, 10);
    reset = 1'b1;
    tick();
    exp_a = '0;
    exp_b = '0;
    check("midrst_compute_en", compute_en, 0);
    check("midrst_load_en", load_en, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_err", err, 0);
    check_bufs("midrst_bufs", in_a, in_b);
    reset = 1'b0;
    tick();
    check("midrst_ready", s_ready, 1);

    // 6: two batches back-to-back, batch 2 offered while batch 1 runs
    for (int r = 0; r < 32; r++) send_beat(r, r == 31, 0);
    set_row(8'hA0, 1'b0);
    s_valid = 1'b1;
    check_batch("two_b1", 0);
    for (int r = 0; r < 32; r++) send_beat(8'hA0 + r, r == 31, 0);
    s_valid = 1'b0;
    s_last  = 1'b0;
    check_batch("two_b2", 8'hA0);
    check("two_err", err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
